map_ram_arbiter: RTL and testbench
==================================

# map_ram_arbiter

Sequencing controller for the write/read port (port B) of the 30×160-bit tile map RAM. It is shared by two movers: requester 0 is pacman location control and requester 1 is ghost location control. Each granted request runs two read-modify-write cycles: it restores the vacated source cell, then writes the destination cell. It returns the tile code found at the destination, which the movers use to detect pills and collisions. Port A stays dedicated to the VGA path; this block is the only master of port B.

## Interface
- RD_LAT, 2: port-B read latency in cycles, from the address cycle to the data-valid cycle. Legal values are 1 to 3.
- CLOCK_50  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  [1:0]  level request per requester. It is held until that requester's done.
- src_x  in  [1:0][5:0]  column of the vacated cell (0–39).
- src_y  in  [1:0][4:0]  row of the vacated cell (0–29).
- dst_x  in  [1:0][5:0]  destination column.
- dst_y  in  [1:0][4:0]  destination row.
- src_code  in  [1:0][3:0]  tile code written into the vacated cell.
- dst_code  in  [1:0][3:0]  tile code written into the destination cell.
- grant  out  [1:0]  one-hot, high for the whole service. Reset value 0.
- done  out  [1:0]  one-hot, 1-cycle pulse at the end of service. Reset value 0.
- hit_code  out  4  prior destination code. Valid with done and held until the next done. Reset value 0.
- err  out  1  pulses with done when coordinates are out of range. Reset value 0.
- busy  out  1  high whenever state is not IDLE. Reset value 0.
- ram_addr  out  5  port-B row address. Reset value 0.
- ram_wren  out  1  port-B write enable. Reset value 0.
- ram_wrdata  out  160  port-B write data. Reset value 0.
- ram_rddata  in  160  port-B read data.

## Operation
- **States:** IDLE, CHK, RD_SRC, WAIT_SRC, WR_SRC, RD_DST, WAIT_DST, WR_DST, DONE.
- **IDLE:** if any req is high, arbitrate, latch the winner's six operands, set grant, and go to CHK. Operands are captured only at grant, so later input changes are ignored.
- **Arbitration:** round-robin with a last-served pointer. The pointer resets to 1, so requester 0 wins the first simultaneous request. The pointer updates at grant.
- **CHK:** if any x > 39 or any y > 29, go to DONE with err=1. Otherwise go to RD_SRC.
- **RD_SRC:** ram_addr = src_y, ram_wren = 0.
- **WAIT_SRC:** lasts RD_LAT−1 cycles; zero cycles when RD_LAT = 1.
- **WR_SRC:** ram_addr = src_y, ram_wren = 1. ram_wrdata is ram_rddata with nibble [159−4·src_x −: 4] replaced by src_code. Column 0 occupies bits [159:156].
- **RD_DST, WAIT_DST, WR_DST:** the same sequence on dst_y / dst_x with dst_code. In WR_DST the old destination nibble is captured into hit_code.
- **DONE:** done[winner] pulses, grant clears, state returns to IDLE.
- **Same row (src_y == dst_y):** the destination read follows the source write, so the new source nibble is preserved.
- **src == dst:** the final nibble is dst_code and hit_code = src_code.
- **Dropped request:** if req drops mid-service, the service still completes and done still pulses.

## Timing
- req is sampled in IDLE at cycle 0. grant is high from cycle 1 (CHK) and deasserts the cycle after DONE.
- Service sequence: RD_SRC at cycle 2, WR_SRC at 2+RD_LAT, RD_DST at 3+RD_LAT, WR_DST at 3+2·RD_LAT, DONE at 4+2·RD_LAT. With the default RD_LAT = 2, done pulses at cycle 8.
- Exactly two ram_wren cycles per valid request. Zero for err requests, which complete with done at cycle 2.
- IDLE is re-entered the cycle after DONE, so the next grant comes at the earliest 2 cycles after done.
- **Reset mid-operation:** the cycle after reset, state is IDLE and all outputs are at their reset values. A pending read-modify-write is abandoned. The RAM is never written with partial data, because writes occur only in single WR cycles.

## Structure
- Shared package map_pkg:
  - MAP_COLS = 40, MAP_ROWS = 30, ROW_BITS = 160, CODE_W = 4.
  - Tile-code enum: EMPTY, WALL, PILL, PACMAN, GHOST, …
  - State enum arb_state_t.
- Sub-module map_row_patch (combinational): inputs row, col, code; outputs the patched row and the old nibble. It is used by both WR states.

## Test plan
1. **Single request.** Preload row 3 with PILL at x=6. Drive req[0] with src (5,3), dst (6,3), src_code=EMPTY, dst_code=PACMAN.
   - done[0] pulses at cycle 8 with hit_code = PILL.
   - Row 3 has x5 = EMPTY and x6 = PACMAN; all other nibbles are unchanged.
   - ram_wren is high in exactly 2 cycles.
2. **Simultaneous requests after reset.** Raise req = 2'b11.
   - Requester 0 gets grant at cycle 1 and done at cycle 8.
   - Requester 1 is sampled at cycle 9 and gets done at cycle 17.
3. **Continuous requests.** Hold both req high for 4 services: grant order is 0, 1, 0, 1.
4. **Out-of-range destination.** Use dst_x = 40: err and done pulse at cycle 2, ram_wren stays 0, and the RAM is unchanged.
5. **src == dst.** Use (10,10) with src_code=EMPTY and dst_code=GHOST: the final nibble is GHOST and hit_code = EMPTY.
6. **Reset mid-service.** Assert reset during WAIT_DST.
   - On the next cycle, grant, busy and ram_wren are all 0.
   - The source write is retained and the destination is untouched.
   - A new req is afterwards served with normal timing.

Source files
------------

// File: rtl/map_pkg.sv
// Shared definitions for the tile map RAM and its port-B arbiter.
// Geometry, tile codes and arbiter state encoding.
package map_pkg;

  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;
  localparam int ROW_BITS = 160;
  localparam int CODE_W   = 4;

  typedef enum logic [3:0] {
    EMPTY  = 4'd0,
    WALL   = 4'd1,
    PILL   = 4'd2,
    PACMAN = 4'd3,
    GHOST  = 4'd4,
    POWER  = 4'd5
  } tile_t;

  typedef enum logic [3:0] {
    IDLE,
    CHK,
    RD_SRC,
    WAIT_SRC,
    WR_SRC,
    RD_DST,
    WAIT_DST,
    WR_DST,
    DONE
  } arb_state_t;

  function automatic logic in_range(
    input logic [5:0] x,
    input logic [4:0] y
  );
    return (x < 6'(MAP_COLS)) &&
           (y < 5'(MAP_ROWS));
  endfunction

endpackage

// File: rtl/map_row_patch.sv
// Replaces one 4-bit cell of a map row; column 0 is the top nibble.
// Also returns the nibble that was overwritten.
module map_row_patch
  import map_pkg::*;
(
  input  logic [ROW_BITS-1:0] row_i,
  input  logic [5:0]          col_i,
  input  logic [CODE_W-1:0]   code_i,
  output logic [ROW_BITS-1:0] row_o,
  output logic [CODE_W-1:0]   old_o
);

  // Walk the columns so every slice index is a constant.
  always_comb begin
    row_o = row_i;
    old_o = '0;
    for (int i = 0; i < MAP_COLS; i++) begin
      if (col_i == 6'(i)) begin
        old_o = row_i[ROW_BITS-1-CODE_W*i -: CODE_W];
        row_o[ROW_BITS-1-CODE_W*i -: CODE_W] = code_i;
      end
    end
  end

endmodule

// File: rtl/map_ram_arbiter.sv
// Round-robin port-B master of the tile map RAM for two movers.
// Each grant does two read-modify-writes: source cell, then destination.
module map_ram_arbiter
  import map_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0][5:0]     src_x,
  input  logic [1:0][4:0]     src_y,
  input  logic [1:0][5:0]     dst_x,
  input  logic [1:0][4:0]     dst_y,
  input  logic [1:0][3:0]     src_code,
  input  logic [1:0][3:0]     dst_code,
  output logic [1:0]          grant,
  output logic [1:0]          done,
  output logic [3:0]          hit_code,
  output logic                err,
  output logic                busy,
  output logic [4:0]          ram_addr,
  output logic                ram_wren,
  output logic [ROW_BITS-1:0] ram_wrdata,
  input  logic [ROW_BITS-1:0] ram_rddata
);

  arb_state_t state_q;

  logic       ptr_q;
  logic [5:0] sx_q;
  logic [4:0] sy_q;
  logic [5:0] dx_q;
  logic [4:0] dy_q;
  logic [3:0] sc_q;
  logic [3:0] dc_q;
  logic [1:0] cnt_q;
  logic [1:0] grant_q;
  logic [1:0] done_q;
  logic [3:0] hit_q;
  logic       err_q;
  logic [4:0] addr_q;
  logic       wren_q;

  logic                win_d;
  logic                wr_dst;
  logic                wr_any;
  logic [5:0]          p_col;
  logic [3:0]          p_code;
  logic [ROW_BITS-1:0] p_row;
  logic [3:0]          p_old;

  // Favour the requester that was not served last.
  always_comb begin
    if (ptr_q) win_d = req[0] ? 1'b0 : 1'b1;
    else       win_d = req[1] ? 1'b1 : 1'b0;
  end

  // Patch operands follow the current write phase.
  always_comb begin
    wr_dst = (state_q == WR_DST);
    wr_any = (state_q == WR_SRC) || wr_dst;
    p_col  = wr_dst ? dx_q : sx_q;
    p_code = wr_dst ? dc_q : sc_q;
  end

  map_row_patch u_patch (
    .row_i  (ram_rddata),
    .col_i  (p_col),
    .code_i (p_code),
    .row_o  (p_row),
    .old_o  (p_old)
  );

  // Sequencer with registered handshake and RAM control outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      sx_q    <= '0;
      sy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sc_q    <= '0;
      dc_q    <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      hit_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            ptr_q   <= win_d;
            sx_q    <= src_x[win_d];
            sy_q    <= src_y[win_d];
            dx_q    <= dst_x[win_d];
            dy_q    <= dst_y[win_d];
            sc_q    <= src_code[win_d];
            dc_q    <= dst_code[win_d];
            grant_q <= win_d ? 2'b10 : 2'b01;
            state_q <= CHK;
          end
        end
        CHK: begin
          if (in_range(sx_q, sy_q) &&
              in_range(dx_q, dy_q)) begin
            addr_q  <= sy_q;
            state_q <= RD_SRC;
          end else begin
            err_q   <= 1'b1;
            done_q  <= grant_q;
            state_q <= DONE;
          end
        end
        RD_SRC: begin
          if (RD_LAT == 1) begin
            wren_q  <= 1'b1;
            state_q <= WR_SRC;
          end else begin
            cnt_q   <= 2'(RD_LAT - 2);
            state_q <= WAIT_SRC;
          end
        end
        WAIT_SRC: begin
          if (cnt_q == '0) begin
            wren_q  <= 1'b1;
            state_q <= WR_SRC;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        WR_SRC: begin
          wren_q  <= 1'b0;
          addr_q  <= dy_q;
          state_q <= RD_DST;
        end
        RD_DST: begin
          if (RD_LAT == 1) begin
            wren_q  <= 1'b1;
            state_q <= WR_DST;
          end else begin
            cnt_q   <= 2'(RD_LAT - 2);
            state_q <= WAIT_DST;
          end
        end
        WAIT_DST: begin
          if (cnt_q == '0) begin
            wren_q  <= 1'b1;
            state_q <= WR_DST;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        WR_DST: begin
          wren_q  <= 1'b0;
          hit_q   <= p_old;
          done_q  <= grant_q;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= '0;
          err_q   <= 1'b0;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign hit_code   = hit_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);
  assign ram_addr   = addr_q;
  assign ram_wren   = wren_q;
  assign ram_wrdata = wr_any ? p_row : '0;

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Directed bench for map_ram_arbiter with a behavioural port-B RAM.
// Cycle 0 is the cycle in which req is first presented.
module tb_map_ram_arbiter;

  localparam int LAT = 2;

  logic           CLOCK_50 = 1'b0;
  logic           reset;
  logic [1:0]     req;
  logic [1:0][5:0] src_x;
  logic [1:0][4:0] src_y;
  logic [1:0][5:0] dst_x;
  logic [1:0][4:0] dst_y;
  logic [1:0][3:0] src_code;
  logic [1:0][3:0] dst_code;
  logic [1:0]     grant;
  logic [1:0]     done;
  logic [3:0]     hit_code;
  logic           err;
  logic           busy;
  logic [4:0]     ram_addr;
  logic           ram_wren;
  logic [159:0]   ram_wrdata;
  logic [159:0]   ram_rddata;

  logic [159:0] mem  [30];
  logic [159:0] pipe [LAT];

  int errors = 0;
  int checks = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  map_ram_arbiter #(.RD_LAT(LAT)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req        (req),
    .src_x      (src_x),
    .src_y      (src_y),
    .dst_x      (dst_x),
    .dst_y      (dst_y),
    .src_code   (src_code),
    .dst_code   (dst_code),
    .grant      (grant),
    .done       (done),
    .hit_code   (hit_code),
    .err        (err),
    .busy       (busy),
    .ram_addr   (ram_addr),
    .ram_wren   (ram_wren),
    .ram_wrdata (ram_wrdata),
    .ram_rddata (ram_rddata)
  );

  always @(posedge CLOCK_50) begin
    if (ram_wren && ram_addr < 5'd30)
      mem[ram_addr] <= ram_wrdata;
    pipe[0] <= (ram_addr < 5'd30) ? mem[ram_addr] : '0;
    for (int i = 1; i < LAT; i++)
      pipe[i] <= pipe[i-1];
  end
  assign ram_rddata = pipe[LAT-1];

  function automatic logic [159:0] set_nib(
    input logic [159:0] row, input int x, input logic [3:0] c);
    logic [159:0] r;
    r = row;
    r[159-4*x -: 4] = c;
    return r;
  endfunction

  function automatic logic [3:0] get_nib(
    input logic [159:0] row, input int x);
    return row[159-4*x -: 4];
  endfunction

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_op(input int r, input int sx, input int sy,
                        input int dx, input int dy,
                        input logic [3:0] sc, input logic [3:0] dc);
    src_x[r]    = 6'(sx);
    src_y[r]    = 5'(sy);
    dst_x[r]    = 6'(dx);
    dst_y[r]    = 5'(dy);
    src_code[r] = sc;
    dst_code[r] = dc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    step();
    step();
    reset = 1'b0;
  endtask

  // Advance until done pulses; cyc is cycles since req was sampled.
  task automatic wait_done(output int cyc, output int nwr,
                           output logic [1:0] d, output logic [3:0] hc,
                           output logic e, output logic [1:0] g1);
    cyc = -1; nwr = 0; d = '0; hc = '0; e = 1'b0; g1 = '0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1) g1 = grant;
      if (ram_wren) nwr++;
      if (done != 2'b00) begin
        cyc = c; d = done; hc = hit_code; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [159:0] wall;
    wall = {40{4'h1}};
    for (int r = 0; r < 30; r++) mem[r] <= wall;
    for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    for (int r = 0; r < 2; r++) set_op(r, 0, 0, 0, 0, 4'h0, 4'h0);
    do_reset();
    #1;
    checks++; if (grant !== 2'b00) begin errors++;
      $display("FAIL reset_grant got=%b want=00", grant); end
    checks++; if (done !== 2'b00) begin errors++;
      $display("FAIL reset_done got=%b want=00", done); end
    checks++; if (hit_code !== 4'h0) begin errors++;
      $display("FAIL reset_hit got=%h want=0", hit_code); end
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (ram_addr !== 5'd0) begin errors++;
      $display("FAIL reset_addr got=%0d want=0", ram_addr); end
    checks++; if (ram_wren !== 1'b0) begin errors++;
      $display("FAIL reset_wren got=%b want=0", ram_wren); end
    checks++; if (ram_wrdata !== 160'd0) begin errors++;
      $display("FAIL reset_wrdata got=%h want=0", ram_wrdata); end
  endtask

  task automatic test_single();
    logic [159:0] r3, e3;
    int cyc, nwr;
    logic [1:0] d, g1;
    logic [3:0] hc;
    logic e;
    r3 = {40{4'h1}};
    r3 = set_nib(r3, 6, 4'h2);
    mem[3] <= r3;
    e3 = set_nib(r3, 5, 4'h0);
    e3 = set_nib(e3, 6, 4'h3);
    set_op(0, 5, 3, 6, 3, 4'h0, 4'h3);
    #1;
    req = 2'b01;
    wait_done(cyc, nwr, d, hc, e, g1);
    req = 2'b00;
    checks++; if (g1 !== 2'b01) begin errors++;
      $display("FAIL single_grant got=%b want=01", g1); end
    checks++; if (cyc !== 8) begin errors++;
      $display("FAIL single_done_cycle got=%0d want=8", cyc); end
    checks++; if (d !== 2'b01) begin errors++;
      $display("FAIL single_done got=%b want=01", d); end
    checks++; if (hc !== 4'h2) begin errors++;
      $display("FAIL single_hit got=%h want=2", hc); end
    checks++; if (e !== 1'b0) begin errors++;
      $display("FAIL single_err got=%b want=0", e); end
    checks++; if (nwr !== 2) begin errors++;
      $display("FAIL single_wren_count got=%0d want=2", nwr); end
    checks++; if (mem[3] !== e3) begin errors++;
      $display("FAIL single_row got=%h want=%h", mem[3], e3); end
    step();
  endtask

  task automatic test_simultaneous();
    int cyc, nwr;
    logic [1:0] d, g1;
    logic [3:0] hc;
    logic e;
    do_reset();
    set_op(0, 1, 1, 2, 1, 4'h0, 4'h3);
    set_op(1, 20, 15, 21, 15, 4'h0, 4'h4);
    req = 2'b11;
    wait_done(cyc, nwr, d, hc, e, g1);
    req = 2'b10;
    checks++; if (g1 !== 2'b01) begin errors++;
      $display("FAIL simul_grant0 got=%b want=01", g1); end
    checks++; if (cyc !== 8 || d !== 2'b01) begin errors++;
      $display("FAIL simul_done0 got=%0d/%b want=8/01", cyc, d); end
    wait_done(cyc, nwr, d, hc, e, g1);
    req = 2'b00;
    checks++; if (cyc + 8 !== 17 || d !== 2'b10) begin errors++;
      $display("FAIL simul_done1 got=%0d/%b want=17/10", cyc + 8, d); end
    checks++; if (get_nib(mem[15], 21) !== 4'h4) begin errors++;
      $display("FAIL simul_row15 got=%h want=4", get_nib(mem[15], 21)); end
    step();
  endtask

  task automatic test_continuous();
    int cyc, nwr;
    logic [1:0] d, g1;
    logic [3:0] hc;
    logic e;
    logic [1:0] want;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      wait_done(cyc, nwr, d, hc, e, g1);
      checks++; if (d !== want) begin errors++;
        $display("FAIL cont_order%0d got=%b want=%b", k, d, want); end
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_err();
    logic [159:0] snap [30];
    int cyc, nwr, bad;
    logic [1:0] d, g1;
    logic [3:0] hc;
    logic e;
    for (int r = 0; r < 30; r++) snap[r] = mem[r];
    set_op(1, 3, 4, 40, 4, 4'h0, 4'h4);
    req = 2'b10;
    wait_done(cyc, nwr, d, hc, e, g1);
    req = 2'b00;
    bad = 0;
    for (int r = 0; r < 30; r++) if (mem[r] !== snap[r]) bad++;
    checks++; if (cyc !== 2 || d !== 2'b10) begin errors++;
      $display("FAIL err_done got=%0d/%b want=2/10", cyc, d); end
    checks++; if (e !== 1'b1) begin errors++;
      $display("FAIL err_flag got=%b want=1", e); end
    checks++; if (nwr !== 0) begin errors++;
      $display("FAIL err_wren got=%0d want=0", nwr); end
    checks++; if (bad !== 0) begin errors++;
      $display("FAIL err_ram rows_changed=%0d want=0", bad); end
    step();
  endtask

  task automatic test_same_cell();
    int cyc, nwr;
    logic [1:0] d, g1;
    logic [3:0] hc;
    logic e;
    mem[10] <= set_nib({40{4'h1}}, 10, 4'h2);
    set_op(0, 10, 10, 10, 10, 4'h0, 4'h4);
    #1;
    req = 2'b01;
    wait_done(cyc, nwr, d, hc, e, g1);
    req = 2'b00;
    checks++; if (cyc !== 8) begin errors++;
      $display("FAIL same_done_cycle got=%0d want=8", cyc); end
    checks++; if (hc !== 4'h0) begin errors++;
      $display("FAIL same_hit got=%h want=0", hc); end
    checks++; if (get_nib(mem[10], 10) !== 4'h4) begin errors++;
      $display("FAIL same_nib got=%h want=4", get_nib(mem[10], 10)); end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc, nwr;
    logic [1:0] d, g1;
    logic [3:0] hc;
    logic e;
    set_op(0, 7, 12, 30, 20, 4'h5, 4'h3);
    req = 2'b01;
    for (int c = 1; c <= 6; c++) step();
    reset = 1'b1;
    req   = 2'b00;
    step();
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++;
      $display("FAIL mid_idle got=%b/%b want=00/0", grant, busy); end
    checks++; if (ram_wren !== 1'b0) begin errors++;
      $display("FAIL mid_wren got=%b want=0", ram_wren); end
    reset = 1'b0;
    checks++; if (get_nib(mem[12], 7) !== 4'h5) begin errors++;
      $display("FAIL mid_src got=%h want=5", get_nib(mem[12], 7)); end
    checks++; if (get_nib(mem[20], 30) !== 4'h1) begin errors++;
      $display("FAIL mid_dst got=%h want=1", get_nib(mem[20], 30)); end
    req = 2'b01;
    wait_done(cyc, nwr, d, hc, e, g1);
    req = 2'b00;
    checks++; if (cyc !== 8 || d !== 2'b01) begin errors++;
      $display("FAIL mid_retry got=%0d/%b want=8/01", cyc, d); end
    checks++; if (nwr !== 2 || hc !== 4'h1) begin errors++;
      $display("FAIL mid_retry_rmw got=%0d/%h want=2/1", nwr, hc); end
    checks++; if (get_nib(mem[20], 30) !== 4'h3) begin errors++;
      $display("FAIL mid_retry_dst got=%h want=3", get_nib(mem[20], 30)); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_continuous();
    test_err();
    test_same_cell();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
